// File: rtl/constants_pkg.sv
// Shared constants for the RV32IM execute stage: datapath width,
// muldiv step count and the major opcodes/funct fields it decodes.
package constants_pkg;

    localparam int XLEN      = 32;
    localparam int MDU_STEPS = 32;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/instruction_pkg.sv
// Decoded-instruction payload passed between pipeline stages, the
// muldiv FSM state type, and operand-signedness helpers for M-ops.
package instruction_pkg;

    typedef struct packed {
        logic                           valid;
        logic [constants_pkg::XLEN-1:0] pc;
        logic [6:0]                     opcode;
        logic [2:0]                     funct3;
        logic [6:0]                     funct7;
        logic [constants_pkg::XLEN-1:0] rs1_data;
        logic [constants_pkg::XLEN-1:0] rs2_data;
        logic [constants_pkg::XLEN-1:0] imm;
        logic [4:0]                     rd;
        logic [constants_pkg::XLEN-1:0] alu_result;
        logic                           reg_data_ready;
    } inst_decoded_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mdu_state_e;

    // rs1 is signed for MUL/MULH/MULHSU and for DIV/REM.
    function automatic logic mdu_a_signed(input logic [2:0] funct3);
        return funct3[2] ? ~funct3[0] : (funct3 != 3'b011);
    endfunction

    // rs2 is signed for MUL/MULH and for DIV/REM.
    function automatic logic mdu_b_signed(input logic [2:0] funct3);
        return funct3[2] ? ~funct3[0] : ~funct3[1];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit. Works on operand magnitudes
// (shift-add for MUL*, restoring division for DIV/REM) and applies the
// sign fix-up and division corner cases when the result is read in DONE.
module muldiv_unit
    import instruction_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    input  logic        ack,
    output logic [31:0] result
);
    import constants_pkg::*;

    mdu_state_e  state;
    logic [4:0]  count;
    logic [2:0]  f3_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] acc;          // mul: {hi, multiplier}; div: {remainder, quotient}

    logic        start_a_neg;
    logic [31:0] start_a_mag;
    logic        is_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] b_mag;

    logic [32:0] mul_sum;
    logic [31:0] rem_shift;
    logic        div_ge;
    logic [31:0] rem_trial;
    logic [63:0] step_next;

    logic [63:0] product;
    logic [31:0] mul_res;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] div_res;

    assign start_a_neg = a[31] & mdu_a_signed(funct3);
    assign start_a_mag = start_a_neg ? -a : a;

    assign is_div = f3_q[2];
    assign a_neg  = a_q[31] & mdu_a_signed(f3_q);
    assign b_neg  = b_q[31] & mdu_b_signed(f3_q);
    assign b_mag  = b_neg ? -b_q : b_q;

    assign busy = (state == BUSY);
    assign done = (state == DONE);

    // Next value of the accumulator after one shift-add or restoring step.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? b_mag : 32'd0)};
        // Remainder is always below the divisor, so a set top bit means the
        // 33-bit shifted value must exceed it; the 32-bit wrapped difference
        // is then exact.
        rem_shift = {acc[62:32], acc[31]};
        div_ge    = acc[63] | (rem_shift >= b_mag);
        rem_trial = div_ge ? (rem_shift - b_mag) : rem_shift;
        step_next = is_div ? {rem_trial, acc[30:0], div_ge}
                           : {mul_sum, acc[31:1]};
    end

    // Sign restoration and division corner cases applied to the final value.
    always_comb begin
        product = (a_neg ^ b_neg) ? -acc : acc;
        mul_res = (f3_q[1:0] == 2'b00) ? product[31:0] : product[63:32];
        quot    = (a_neg ^ b_neg) ? -acc[31:0] : acc[31:0];
        rem     = a_neg ? -acc[63:32] : acc[63:32];
        if (b_q == '0) begin
            quot = '1;
            rem  = a_q;
        end else if (!f3_q[0] && (a_q == 32'h8000_0000) && (b_q == '1)) begin
            quot = 32'h8000_0000;
            rem  = '0;
        end
        div_res = f3_q[1] ? rem : quot;
        result  = is_div ? div_res : mul_res;
    end

    // Control FSM: IDLE -> BUSY for MDU_STEPS cycles -> DONE until acknowledged.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        count <= '0;
                    end
                end
                BUSY: begin
                    if (count == 5'(MDU_STEPS - 1)) begin
                        state <= DONE;
                        count <= '0;
                    end else begin
                        count <= count + 5'd1;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand latch at start and one datapath step per BUSY cycle.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; the FSM guarantees they are
        // loaded on start before anything reads them.
        if ((state == IDLE) && start) begin
            f3_q <= funct3;
            a_q  <= a;
            b_q  <= b;
            acc  <= {32'd0, start_a_mag};
        end else if (state == BUSY) begin
            acc <= step_next;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// RV32IM execute stage: single-cycle ALU, branch/jump resolution, the
// EX/MEM pipeline register, and the iterative muldiv unit which stalls
// decode while it works.
module execute_stage
    import instruction_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit M_EXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  inst_decoded_t   inst_exe_in,
    output inst_decoded_t   inst_exe_out,
    input  logic            stall_exe_in,
    output logic            stall_exe_out,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target
);
    import constants_pkg::*;

    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;

    logic            is_mop;
    logic            legal;
    logic [XLEN-1:0] alu_result;
    logic            reg_ready;
    logic            br_taken;
    logic [XLEN-1:0] br_target;

    logic            mdu_start;
    logic            mdu_busy;
    logic            mdu_done;
    logic [XLEN-1:0] mdu_result;
    inst_decoded_t   m_inst;

    assign rs1   = inst_exe_in.rs1_data;
    assign rs2   = inst_exe_in.rs2_data;
    assign imm   = inst_exe_in.imm;
    assign pc    = inst_exe_in.pc;
    assign op_b  = (inst_exe_in.opcode == OPCODE_OPIMM) ? imm : rs2;
    assign shamt = op_b[4:0];

    assign is_mop = (inst_exe_in.opcode == OPCODE_OP) &&
                    (inst_exe_in.funct7 == FUNCT7_MULDIV);

    // Decode holds while the unit is working, finishing, or memory is stalled.
    assign stall_exe_out = stall_exe_in | mdu_busy | mdu_done;
    assign mdu_start     = M_EXT && inst_exe_in.valid && is_mop && !stall_exe_out;

    muldiv_unit u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (mdu_start),
        .funct3 (inst_exe_in.funct3),
        .a      (rs1),
        .b      (rs2),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .ack    (!stall_exe_in),
        .result (mdu_result)
    );

    // Single-cycle ALU, address/link generation and branch resolution.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        alu_result = '0;
        reg_ready  = 1'b1;
        br_taken   = 1'b0;
        br_target  = '0;
        legal      = 1'b1;
        case (inst_exe_in.opcode)
            OPCODE_OP, OPCODE_OPIMM: begin
                legal = !is_mop;
                case (inst_exe_in.funct3)
                    3'b000: alu_result = ((inst_exe_in.opcode == OPCODE_OP) && inst_exe_in.funct7[5])
                                         ? (rs1 - op_b) : (rs1 + op_b);
                    3'b001: alu_result = rs1 << shamt;
                    3'b010: alu_result = {31'd0, ($signed(rs1) < $signed(op_b))};
                    3'b011: alu_result = {31'd0, (rs1 < op_b)};
                    3'b100: alu_result = rs1 ^ op_b;
                    3'b101: alu_result = inst_exe_in.funct7[5] ? $unsigned($signed(rs1) >>> shamt)
                                                               : (rs1 >> shamt);
                    3'b110: alu_result = rs1 | op_b;
                    default: alu_result = rs1 & op_b;
                endcase
            end
            OPCODE_LUI:   alu_result = imm;
            OPCODE_AUIPC: alu_result = pc + imm;
            OPCODE_LOAD: begin
                alu_result = rs1 + imm;
                reg_ready  = 1'b0;
            end
            OPCODE_STORE: alu_result = rs1 + imm;
            OPCODE_JAL: begin
                alu_result = pc + 32'd4;
                br_taken   = 1'b1;
                br_target  = pc + imm;
            end
            OPCODE_JALR: begin
                alu_result = pc + 32'd4;
                br_taken   = 1'b1;
                br_target  = (rs1 + imm) & ~32'd1;
            end
            OPCODE_BRANCH: begin
                br_target = pc + imm;
                case (inst_exe_in.funct3)
                    3'b000:  br_taken = (rs1 == rs2);
                    3'b001:  br_taken = (rs1 != rs2);
                    3'b100:  br_taken = ($signed(rs1) <  $signed(rs2));
                    3'b101:  br_taken = ($signed(rs1) >= $signed(rs2));
                    3'b110:  br_taken = (rs1 <  rs2);
                    3'b111:  br_taken = (rs1 >= rs2);
                    default: legal    = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    // EX/MEM register and branch pulse: hold under downstream stall, else
    // load the muldiv result, a single-cycle result, or a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_exe_out  <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else if (!stall_exe_in) begin
            inst_exe_out  <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
            if (mdu_done) begin
                inst_exe_out                <= m_inst;
                inst_exe_out.alu_result     <= mdu_result;
                inst_exe_out.reg_data_ready <= 1'b1;
            end else if (!mdu_busy && inst_exe_in.valid && legal) begin
                inst_exe_out                <= inst_exe_in;
                inst_exe_out.alu_result     <= alu_result;
                inst_exe_out.reg_data_ready <= reg_ready;
                branch_taken                <= br_taken;
                branch_target               <= br_target;
            end
        end
    end

    // Payload of the accepted M-op, replayed when its result is registered.
    always_ff @(posedge clk) begin
        if (mdu_start) begin
            m_inst <= inst_exe_in;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: reset, ALU ops,
// branches/jumps, muldiv results and latency, downstream stall at
// completion, and reset during a multi-cycle operation.
module tb_execute_stage;
    import constants_pkg::*;
    import instruction_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    inst_decoded_t inst_in;
    inst_decoded_t inst_out;
    logic          stall_in;
    logic          stall_out;
    logic          br_taken;
    logic [31:0]   br_target;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        inst_decoded_t inst;
        logic [31:0]   exp;
        logic          exp_ready;
    } alu_vec_t;

    always #5 clk = ~clk;

    execute_stage #(.XLEN(32), .M_EXT(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_exe_in   (inst_in),
        .inst_exe_out  (inst_out),
        .stall_exe_in  (stall_in),
        .stall_exe_out (stall_out),
        .branch_taken  (br_taken),
        .branch_target (br_target)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic inst_decoded_t mk(input logic [6:0] opcode, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] imm,
                                         input logic [31:0] pc, input logic [4:0] rd);
        inst_decoded_t t;
        t                = '0;
        t.valid          = 1'b1;
        t.opcode         = opcode;
        t.funct3         = f3;
        t.funct7         = f7;
        t.rs1_data       = a;
        t.rs2_data       = b;
        t.imm            = imm;
        t.pc             = pc;
        t.rd             = rd;
        return t;
    endfunction

    task automatic test_reset;
        rst      = 1'b1;
        stall_in = 1'b0;
        inst_in  = mk(OPCODE_OP, 3'b000, 7'd0, 32'd1, 32'd2, 32'd0, 32'h10, 5'd3);
        tick();
        tick();
        n_total++; if (inst_out !== '0) $display("FAIL reset_out got %h want 0", inst_out); else n_pass++;
        n_total++; if (stall_out !== 1'b0) $display("FAIL reset_stall got %b want 0", stall_out); else n_pass++;
        n_total++; if (br_taken !== 1'b0) $display("FAIL reset_taken got %b want 0", br_taken); else n_pass++;
        n_total++; if (br_target !== 32'd0) $display("FAIL reset_target got %h want 0", br_target); else n_pass++;
        rst     = 1'b0;
        inst_in = '0;
        tick();
    endtask

    task automatic test_alu;
        alu_vec_t vecs[7];
        inst_in = mk(OPCODE_OPIMM, 3'b000, 7'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h40, 5'd1);
        tick();
        n_total++; if (inst_out.alu_result !== 32'hFFFF_FFFF) $display("FAIL addi_result got %h want ffffffff", inst_out.alu_result); else n_pass++;
        n_total++; if (inst_out.valid !== 1'b1 || inst_out.rd !== 5'd1) $display("FAIL addi_valid_rd got %b/%0d want 1/1", inst_out.valid, inst_out.rd); else n_pass++;
        n_total++; if (stall_out !== 1'b0) $display("FAIL addi_stall got %b want 0", stall_out); else n_pass++;
        inst_in = mk(OPCODE_OP, 3'b000, 7'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h44, 5'd2);
        tick();
        n_total++; if (inst_out.alu_result !== 32'h8000_0000) $display("FAIL add_result got %h want 80000000", inst_out.alu_result); else n_pass++;
        n_total++; if (inst_out.valid !== 1'b1 || inst_out.pc !== 32'h44) $display("FAIL add_valid_pc got %b/%h want 1/44", inst_out.valid, inst_out.pc); else n_pass++;
        n_total++; if (stall_out !== 1'b0) $display("FAIL add_stall got %b want 0", stall_out); else n_pass++;

        vecs[0] = '{mk(OPCODE_OP,    3'b000, 7'b0100000, 32'd5,         32'd7,         32'd0,          32'h0,    5'd4), 32'hFFFF_FFFE, 1'b1}; // SUB
        vecs[1] = '{mk(OPCODE_OPIMM, 3'b101, 7'b0100000, 32'h8000_0000, 32'd0,         32'h404,        32'h0,    5'd4), 32'hF800_0000, 1'b1}; // SRAI 4
        vecs[2] = '{mk(OPCODE_OP,    3'b011, 7'd0,       32'd1,         32'hFFFF_FFFF, 32'd0,          32'h0,    5'd4), 32'd1,         1'b1}; // SLTU
        vecs[3] = '{mk(OPCODE_OP,    3'b010, 7'd0,       32'd1,         32'hFFFF_FFFF, 32'd0,          32'h0,    5'd4), 32'd0,         1'b1}; // SLT
        vecs[4] = '{mk(OPCODE_LUI,   3'b000, 7'd0,       32'd0,         32'd0,         32'h1234_5000,  32'h0,    5'd4), 32'h1234_5000, 1'b1}; // LUI
        vecs[5] = '{mk(OPCODE_AUIPC, 3'b000, 7'd0,       32'd0,         32'd0,         32'h2000,       32'h1000, 5'd4), 32'h3000,      1'b1}; // AUIPC
        vecs[6] = '{mk(OPCODE_LOAD,  3'b010, 7'd0,       32'h100,       32'd0,         32'hFFFF_FFFC,  32'h0,    5'd4), 32'hFC,        1'b0}; // LW
        for (int i = 0; i < 7; i++) begin
            inst_in = vecs[i].inst;
            tick();
            n_total++; if (inst_out.alu_result !== vecs[i].exp) $display("FAIL alu_vec%0d_result got %h want %h", i, inst_out.alu_result, vecs[i].exp); else n_pass++;
            n_total++; if (inst_out.reg_data_ready !== vecs[i].exp_ready || inst_out.valid !== 1'b1) $display("FAIL alu_vec%0d_ready_valid got %b/%b want %b/1", i, inst_out.reg_data_ready, inst_out.valid, vecs[i].exp_ready); else n_pass++;
        end
        inst_in = '0;
        tick();
        n_total++; if (inst_out.valid !== 1'b0) $display("FAIL bubble_valid got %b want 0", inst_out.valid); else n_pass++;
    endtask

    task automatic test_branch;
        inst_in = mk(OPCODE_BRANCH, 3'b100, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd0);
        tick();
        n_total++; if (br_taken !== 1'b1) $display("FAIL blt_taken got %b want 1", br_taken); else n_pass++;
        n_total++; if (br_target !== 32'h120) $display("FAIL blt_target got %h want 120", br_target); else n_pass++;
        inst_in = '0;
        tick();
        n_total++; if (br_taken !== 1'b0 || br_target !== 32'd0) $display("FAIL blt_clear got %b/%h want 0/0", br_taken, br_target); else n_pass++;

        inst_in = mk(OPCODE_JALR, 3'b000, 7'd0, 32'h203, 32'd0, 32'd0, 32'h100, 5'd1);
        tick();
        n_total++; if (br_taken !== 1'b1 || br_target !== 32'h202) $display("FAIL jalr_target got %b/%h want 1/202", br_taken, br_target); else n_pass++;
        n_total++; if (inst_out.alu_result !== 32'h104) $display("FAIL jalr_link got %h want 104", inst_out.alu_result); else n_pass++;

        inst_in = mk(OPCODE_BRANCH, 3'b000, 7'd0, 32'd1, 32'd2, 32'h40, 32'h100, 5'd0);
        tick();
        n_total++; if (br_taken !== 1'b0) $display("FAIL beq_not_taken got %b want 0", br_taken); else n_pass++;

        inst_in = mk(OPCODE_JAL, 3'b000, 7'd0, 32'd0, 32'd0, 32'h20, 32'hFFFF_FFF0, 5'd1);
        tick();
        n_total++; if (br_target !== 32'h10 || br_taken !== 1'b1) $display("FAIL jal_wrap_target got %b/%h want 1/10", br_taken, br_target); else n_pass++;
        n_total++; if (inst_out.alu_result !== 32'hFFFF_FFF4) $display("FAIL jal_link got %h want fffffff4", inst_out.alu_result); else n_pass++;

        inst_in = mk(OPCODE_BRANCH, 3'b111, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h200, 5'd0);
        tick();
        n_total++; if (br_taken !== 1'b1 || br_target !== 32'h1F8) $display("FAIL bgeu_target got %b/%h want 1/1f8", br_taken, br_target); else n_pass++;
        stall_in = 1'b1;
        inst_in  = mk(OPCODE_OP, 3'b000, 7'd0, 32'd1, 32'd1, 32'd0, 32'h204, 5'd2);
        tick();
        tick();
        n_total++; if (br_taken !== 1'b1 || br_target !== 32'h1F8) $display("FAIL stall_hold_branch got %b/%h want 1/1f8", br_taken, br_target); else n_pass++;
        n_total++; if (inst_out.opcode !== OPCODE_BRANCH || stall_out !== 1'b1) $display("FAIL stall_hold_out got %h/%b want 63/1", inst_out.opcode, stall_out); else n_pass++;
        stall_in = 1'b0;
        tick();
        n_total++; if (br_taken !== 1'b0 || inst_out.alu_result !== 32'd2) $display("FAIL stall_release got %b/%h want 0/2", br_taken, inst_out.alu_result); else n_pass++;
        inst_in = '0;
        tick();
    endtask

    task automatic test_mop(input string name, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int stalls;
        int lat;
        stalls  = 0;
        lat     = 0;
        inst_in = mk(OPCODE_OP, f3, FUNCT7_MULDIV, a, b, 32'd0, 32'h300, 5'd5);
        tick();
        n_total++; if (inst_out.valid !== 1'b0) $display("FAIL %s_accept_bubble got %b want 0", name, inst_out.valid); else n_pass++;
        inst_in = '0;
        for (int k = 1; k <= 40; k++) begin
            if (stall_out) stalls++;
            tick();
            if (inst_out.valid) begin
                lat = k;
                break;
            end
        end
        n_total++; if (lat != 33) $display("FAIL %s_latency got %0d want 33", name, lat); else n_pass++;
        n_total++; if (stalls != 33) $display("FAIL %s_stall_cycles got %0d want 33", name, stalls); else n_pass++;
        n_total++; if (inst_out.alu_result !== exp) $display("FAIL %s_result got %h want %h", name, inst_out.alu_result, exp); else n_pass++;
        n_total++; if (inst_out.rd !== 5'd5 || inst_out.reg_data_ready !== 1'b1) $display("FAIL %s_rd_ready got %0d/%b want 5/1", name, inst_out.rd, inst_out.reg_data_ready); else n_pass++;
        n_total++; if (stall_out !== 1'b0) $display("FAIL %s_stall_release got %b want 0", name, stall_out); else n_pass++;
        tick();
        n_total++; if (inst_out.valid !== 1'b0) $display("FAIL %s_no_duplicate got %b want 0", name, inst_out.valid); else n_pass++;
    endtask

    task automatic test_stall_at_done;
        int seen;
        seen    = 0;
        inst_in = mk(OPCODE_OP, 3'b101, FUNCT7_MULDIV, 32'd100, 32'd7, 32'd0, 32'h400, 5'd6);
        tick();
        inst_in = '0;
        repeat (32) tick();
        n_total++; if (stall_out !== 1'b1 || inst_out.valid !== 1'b0) $display("FAIL sd_pre_done got %b/%b want 1/0", stall_out, inst_out.valid); else n_pass++;
        stall_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (inst_out.valid) seen++;
        end
        n_total++; if (seen != 0) $display("FAIL sd_valid_while_stalled got %0d want 0", seen); else n_pass++;
        n_total++; if (stall_out !== 1'b1) $display("FAIL sd_stall_out got %b want 1", stall_out); else n_pass++;
        stall_in = 1'b0;
        tick();
        n_total++; if (inst_out.valid !== 1'b1 || inst_out.alu_result !== 32'd14) $display("FAIL sd_result got %b/%h want 1/e", inst_out.valid, inst_out.alu_result); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (inst_out.valid) seen++;
        end
        n_total++; if (seen != 0) $display("FAIL sd_extra_entries got %0d want 0", seen); else n_pass++;
    endtask

    task automatic test_reset_mid_op;
        int seen;
        seen    = 0;
        inst_in = mk(OPCODE_OP, 3'b000, FUNCT7_MULDIV, 32'd5, 32'd6, 32'd0, 32'h500, 5'd8);
        tick();
        inst_in = '0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        n_total++; if (inst_out !== '0) $display("FAIL rm_out got %h want 0", inst_out); else n_pass++;
        n_total++; if (stall_out !== 1'b0) $display("FAIL rm_stall got %b want 0", stall_out); else n_pass++;
        n_total++; if (br_taken !== 1'b0 || br_target !== 32'd0) $display("FAIL rm_branch got %b/%h want 0/0", br_taken, br_target); else n_pass++;
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (inst_out.valid) seen++;
        end
        n_total++; if (seen != 0) $display("FAIL rm_aborted_result got %0d want 0", seen); else n_pass++;
        inst_in = mk(OPCODE_OP, 3'b000, 7'd0, 32'd2, 32'd3, 32'd0, 32'h600, 5'd9);
        tick();
        n_total++; if (inst_out.valid !== 1'b1 || inst_out.alu_result !== 32'd5) $display("FAIL rm_add_after got %b/%h want 1/5", inst_out.valid, inst_out.alu_result); else n_pass++;
        inst_in = '0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        stall_in = 1'b0;
        inst_in  = '0;
        test_reset();
        test_alu();
        test_branch();
        test_mop("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        test_mop("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        test_mop("mul",    3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB);
        test_mop("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
        test_mop("div0",   3'b100, 32'd7,         32'd0,         32'hFFFF_FFFF);
        test_mop("rem0",   3'b110, 32'd7,         32'd0,         32'd7);
        test_mop("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        test_mop("remneg", 3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        test_mop("divneg", 3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        test_mop("remu",   3'b111, 32'hFFFF_FFFF, 32'd10,        32'd5);
        test_stall_at_done();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
